// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : regfile_write_arbiter
// Purpose  : Shares the register file write port between ALU and load
//            writeback. The arbiter grants the older slot first and breaks
//            ties round-robin. Defining REGWR_FWD_EN adds read-stage bypass
//            ports.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int DATA_W           = 32,
   parameter int ADDR_W           = 5,
   parameter int ZERO_REG_PROTECT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              rf_w_en,
   output logic [ADDR_W-1:0] rf_w_addr,
   output logic [DATA_W-1:0] rf_w_data,
   output logic              grant_id,
   output logic              busy,
   output logic [15:0]       stall_count
`ifdef REGWR_FWD_EN
   ,
   input  logic [ADDR_W-1:0] rd_addr_s1,
   input  logic [ADDR_W-1:0] rd_addr_s2,
   output logic              fwd_s1_hit,
   output logic              fwd_s2_hit,
   output logic [DATA_W-1:0] fwd_s1_data,
   output logic [DATA_W-1:0] fwd_s2_data
`endif
);

   logic              slot0_full;
   logic              slot1_full;
   logic [ADDR_W-1:0] slot0_addr;
   logic [ADDR_W-1:0] slot1_addr;
   logic [DATA_W-1:0] slot0_data;
   logic [DATA_W-1:0] slot1_data;
   logic              age;
   logic              tie;
   logic              rr;

   logic gnt_any;
   logic gnt_id;
   logic tie_break;
   logic drain0;
   logic drain1;
   logic stay0;
   logic stay1;
   logic fill0;
   logic fill1;
   logic stall_evt;

   // age names the older slot; tie marks both slots loaded on the same edge
   always_comb begin
      gnt_any = slot0_full | slot1_full;
      gnt_id  = 1'b0;
      if (slot0_full && slot1_full) begin
         gnt_id = tie ? rr : age;
      end else begin
         gnt_id = slot1_full;
      end
   end

   assign tie_break = slot0_full & slot1_full & tie;
   assign drain0    = slot0_full & ~gnt_id;
   assign drain1    = slot1_full & gnt_id;
   assign stay0     = slot0_full & ~drain0;
   assign stay1     = slot1_full & ~drain1;
   assign stall_evt = stay0 | stay1;

   assign req0_ready = ~slot0_full | drain0;
   assign req1_ready = ~slot1_full | drain1;
   assign busy       = slot0_full | slot1_full;

   // A write to r0 completes the handshake but never occupies a slot
   assign fill0 = req0_valid & req0_ready &
                  ~((ZERO_REG_PROTECT != 0) && (req0_addr == '0));
   assign fill1 = req1_valid & req1_ready &
                  ~((ZERO_REG_PROTECT != 0) && (req1_addr == '0));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot0_full  <= 1'b0;
         slot1_full  <= 1'b0;
         slot0_addr  <= '0;
         slot1_addr  <= '0;
         slot0_data  <= '0;
         slot1_data  <= '0;
         age         <= 1'b0;
         tie         <= 1'b0;
         rr          <= 1'b0;
         rf_w_en     <= 1'b0;
         rf_w_addr   <= '0;
         rf_w_data   <= '0;
         grant_id    <= 1'b0;
         stall_count <= 16'h0000;
      end else begin
         slot0_full <= fill0 | stay0;
         slot1_full <= fill1 | stay1;
         if (fill0) begin
            slot0_addr <= req0_addr;
            slot0_data <= req0_data;
         end
         if (fill1) begin
            slot1_addr <= req1_addr;
            slot1_data <= req1_data;
         end

         if (stay0 && fill1) begin
            age <= 1'b0;
            tie <= 1'b0;
         end else if (stay1 && fill0) begin
            age <= 1'b1;
            tie <= 1'b0;
         end else begin
            tie <= fill0 & fill1;
         end

         if (tie_break) begin
            rr <= ~rr;
         end

         rf_w_en <= gnt_any;
         if (gnt_any) begin
            rf_w_addr <= gnt_id ? slot1_addr : slot0_addr;
            rf_w_data <= gnt_id ? slot1_data : slot0_data;
            grant_id  <= gnt_id;
         end

         if (stall_evt && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end

`ifdef REGWR_FWD_EN
   assign fwd_s1_hit  = rf_w_en && (rf_w_addr == rd_addr_s1) && (rf_w_addr != '0);
   assign fwd_s2_hit  = rf_w_en && (rf_w_addr == rd_addr_s2) && (rf_w_addr != '0);
   assign fwd_s1_data = rf_w_data;
   assign fwd_s2_data = rf_w_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed stimulus against a timestamp-ordered reference model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 1'b0;
   logic [AW-1:0] req0_addr  = '0;
   logic [DW-1:0] req0_data  = '0;
   logic          req0_ready;
   logic          req1_valid = 1'b0;
   logic [AW-1:0] req1_addr  = '0;
   logic [DW-1:0] req1_data  = '0;
   logic          req1_ready;
   logic          rf_w_en;
   logic [AW-1:0] rf_w_addr;
   logic [DW-1:0] rf_w_data;
   logic          grant_id;
   logic          busy;
   logic [15:0]   stall_count;

   always #5 clock = ~clock;

   regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG_PROTECT(1)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
      .req1_ready(req1_ready),
      .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
      .grant_id(grant_id), .busy(busy), .stall_count(stall_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each slot carries the cycle it was accepted in
   bit            m_full [2];
   logic [AW-1:0] m_addr [2];
   logic [DW-1:0] m_data [2];
   int            m_stamp[2];
   bit            m_rr;
   int            m_cyc;
   logic          m_en;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   logic          m_gid;
   int            m_stall;
   logic [DW-1:0] rf_seen[32];

   function automatic int m_pick();
      if (m_full[0] && m_full[1]) begin
         if (m_stamp[0] < m_stamp[1]) return 0;
         if (m_stamp[1] < m_stamp[0]) return 1;
         return m_rr ? 1 : 0;
      end
      if (m_full[0]) return 0;
      if (m_full[1]) return 1;
      return -1;
   endfunction

   task automatic m_clear();
      for (int k = 0; k < 2; k++) begin
         m_full[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0; m_stamp[k] = 0;
      end
      m_rr = 1'b0; m_en = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = 1'b0; m_stall = 0;
   endtask

   task automatic m_step();
      int g;
      bit rdy0, rdy1, tie, stalled;
      g       = m_pick();
      rdy0    = !m_full[0] || (g == 0);
      rdy1    = !m_full[1] || (g == 1);
      tie     = m_full[0] && m_full[1] && (m_stamp[0] == m_stamp[1]);
      stalled = (m_full[0] && g != 0) || (m_full[1] && g != 1);
      m_en    = (g >= 0);
      if (g >= 0) begin
         m_waddr = m_addr[g[0]];
         m_wdata = m_data[g[0]];
         m_gid   = g[0];
         m_full[g[0]] = 1'b0;
      end
      if (stalled && m_stall < 65535) m_stall++;
      if (tie) m_rr = !m_rr;
      if (req0_valid && rdy0 && req0_addr != '0) begin
         m_full[0] = 1'b1; m_addr[0] = req0_addr; m_data[0] = req0_data; m_stamp[0] = m_cyc;
      end
      if (req1_valid && rdy1 && req1_addr != '0) begin
         m_full[1] = 1'b1; m_addr[1] = req1_addr; m_data[1] = req1_data; m_stamp[1] = m_cyc;
      end
      m_cyc++;
   endtask

   initial begin
      m_cyc = 0;
      m_clear();
      forever begin
         @(posedge clock or posedge reset);
         if (reset) m_clear();
         else m_step();
      end
   end

   initial begin
      for (int k = 0; k < 32; k++) rf_seen[k] = '0;
      forever begin
         @(posedge clock);
         if (!reset && rf_w_en) rf_seen[rf_w_addr] = rf_w_data;
      end
   end

   initial begin
      forever begin
         int g;
         @(negedge clock);
         g = m_pick();
         chk("m_rf_w_en",   rf_w_en,     m_en);
         chk("m_rf_w_addr", rf_w_addr,   m_waddr);
         chk("m_rf_w_data", rf_w_data,   m_wdata);
         chk("m_grant_id",  grant_id,    m_gid);
         chk("m_stall",     stall_count, m_stall[15:0]);
         chk("m_busy",      busy,        m_full[0] | m_full[1]);
         chk("m_ready0",    req0_ready,  !m_full[0] || (g == 0));
         chk("m_ready1",    req1_ready,  !m_full[1] || (g == 1));
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req0_valid = v; req0_addr = a; req0_data = d;
   endtask

   task automatic drive1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req1_valid = v; req1_addr = a; req1_data = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive0(1'b0, '0, '0);
      drive1(1'b0, '0, '0);
      tick();
      tick();
      @(negedge clock);
      #1 reset = 1'b0;
      tick();
   endtask

   initial begin
      int run0, run1, max0, max1;
      logic [DW-1:0] d0, d1;
      logic r0, r1;

      // single ALU write
      do_reset();
      chk("rst_en", rf_w_en, 0);
      chk("rst_stall", stall_count, 0);
      drive0(1'b1, 5'd3, 32'hA5A5_0001);
      tick();
      drive0(1'b0, '0, '0);
      chk("t1_en_early", rf_w_en, 0);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_en", rf_w_en, 1);
      chk("t1_addr", rf_w_addr, 3);
      chk("t1_data", rf_w_data, 32'hA5A5_0001);
      chk("t1_gid", grant_id, 0);
      chk("t1_stall", stall_count, 0);
      tick();
      chk("t1_en_off", rf_w_en, 0);

      // same-edge tie, then repeat tie with toggled pointer
      do_reset();
      drive0(1'b1, 5'd5, 32'h11);
      drive1(1'b1, 5'd6, 32'h22);
      tick();
      drive0(1'b0, '0, '0);
      drive1(1'b0, '0, '0);
      tick();
      chk("t2_gid_a", grant_id, 0);
      chk("t2_addr_a", rf_w_addr, 5);
      chk("t2_stall_a", stall_count, 1);
      tick();
      chk("t2_gid_b", grant_id, 1);
      chk("t2_data_b", rf_w_data, 32'h22);
      chk("t2_stall_b", stall_count, 1);
      tick();
      drive0(1'b1, 5'd5, 32'h33);
      drive1(1'b1, 5'd6, 32'h44);
      tick();
      drive0(1'b0, '0, '0);
      drive1(1'b0, '0, '0);
      tick();
      chk("t2_gid_c", grant_id, 1);
      chk("t2_data_c", rf_w_data, 32'h44);
      chk("t2_stall_c", stall_count, 2);
      tick();
      chk("t2_gid_d", grant_id, 0);
      chk("t2_data_d", rf_w_data, 32'h33);

      // same-address ordering
      do_reset();
      drive1(1'b1, 5'd7, 32'h77);
      tick();
      drive1(1'b0, '0, '0);
      drive0(1'b1, 5'd7, 32'h88);
      tick();
      drive0(1'b0, '0, '0);
      chk("t3_data_a", rf_w_data, 32'h77);
      chk("t3_gid_a", grant_id, 1);
      tick();
      chk("t3_data_b", rf_w_data, 32'h88);
      chk("t3_gid_b", grant_id, 0);
      chk("t3_r7_mid", rf_seen[7], 32'h77);
      tick();
      chk("t3_r7_final", rf_seen[7], 32'h88);

      // write to r0 is swallowed
      do_reset();
      drive0(1'b1, 5'd0, 32'hDEAD);
      #1;
      chk("t4_ready0", req0_ready, 1);
      tick();
      drive0(1'b0, '0, '0);
      chk("t4_busy", busy, 0);
      chk("t4_en_a", rf_w_en, 0);
      tick();
      chk("t4_en_b", rf_w_en, 0);

      // sustained back-to-back traffic
      do_reset();
      d0 = 32'h1000;
      d1 = 32'h2000;
      drive0(1'b1, 5'd10, d0);
      drive1(1'b1, 5'd20, d1);
      run0 = 0; run1 = 0; max0 = 0; max1 = 0;
      for (int i = 0; i < 20; i++) begin
         r0 = req0_ready;
         r1 = req1_ready;
         run0 = r0 ? 0 : run0 + 1;
         run1 = r1 ? 0 : run1 + 1;
         if (run0 > max0) max0 = run0;
         if (run1 > max1) max1 = run1;
         tick();
         if (r0) begin d0 = d0 + 1; req0_data = d0; end
         if (r1) begin d1 = d1 + 1; req1_data = d1; end
         if (i >= 1) begin
            chk("t5_en", rf_w_en, 1);
            chk("t5_gid", grant_id, ((i - 1) % 2 == 1) ? 1 : 0);
            chk("t5_addr", rf_w_addr, ((i - 1) % 2 == 1) ? 20 : 10);
         end
      end
      chk("t5_low0", max0 <= 1, 1);
      chk("t5_low1", max1 <= 1, 1);
      drive0(1'b0, '0, '0);
      drive1(1'b0, '0, '0);

      // asynchronous reset mid-traffic
      do_reset();
      drive0(1'b1, 5'd12, 32'hC0);
      drive1(1'b1, 5'd13, 32'hC1);
      tick();
      tick();
      chk("t6_en_pre", rf_w_en, 1);
      chk("t6_busy_pre", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_en_rst", rf_w_en, 0);
      chk("t6_busy_rst", busy, 0);
      chk("t6_stall_rst", stall_count, 0);
      drive0(1'b0, '0, '0);
      drive1(1'b0, '0, '0);
      tick();
      @(negedge clock);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_en_after", rf_w_en, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between two writeback requesters: req0 is the ALU result and req1 is the load/memory result. Each requester has a 1-entry holding slot with a valid/ready handshake. Arbitration is age-ordered with a round-robin tie-break. The block drives the register file's write enable, destination address and write data from registered outputs, and keeps a saturating stall counter for performance debug.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register address
ZERO_REG_PROTECT, 1, when 1, writes to address 0 are accepted and discarded

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
req0_valid  input  1  ALU writeback request
req0_addr  input  ADDR_W  ALU destination register
req0_data  input  DATA_W  ALU result
req0_ready  output  1  slot0 can accept this cycle
req1_valid  input  1  load writeback request
req1_addr  input  ADDR_W  load destination register
req1_data  input  DATA_W  load data
req1_ready  output  1  slot1 can accept this cycle
rf_w_en  output  1  register file write enable (registered)
rf_w_addr  output  ADDR_W  register file destination address (registered)
rf_w_data  output  DATA_W  register file write data (registered)
grant_id  output  1  source of the current rf_w_* write (registered)
busy  output  1  at least one slot is full (combinational from state)
stall_count  output  16  saturating count of cycles with a slot full but not granted

Behaviour:
- Reset (async, active-high):
  - slot0_full = slot1_full = 0; age bit = 0; rr pointer = 0.
  - rf_w_en = 0, rf_w_addr = 0, rf_w_data = 0, grant_id = 0, stall_count = 0.
  - Pending writes are dropped. Reset asserted mid-operation forces rf_w_en low immediately, without waiting for a clock edge.
- Handshake:
  - reqN_ready = !slotN_full || grant_this_cycle == N (combinational).
  - A transfer occurs on a posedge when valid && ready.
  - The requester must hold addr/data stable while valid && !ready.
- Accept:
  - On transfer, slotN is loaded with {addr, data} and set full, except when ZERO_REG_PROTECT=1 and addr==0. In that case the transfer completes and the slot is not filled.
  - A granted slot may be refilled on the same edge it drains, giving 1 write per cycle per requester.
- Arbitration (combinational, from slot state only):
  - Only one slot full: grant it.
  - Both full: grant the older slot. The age bit records which slot filled first.
  - Both filled on the same edge: grant per the rr pointer (0 selects req0). The pointer toggles after every tie-break.
  - No incoming request bypasses a slot.
- Output:
  - On each posedge, rf_w_en <= any grant, and rf_w_addr, rf_w_data, grant_id <= the granted slot.
  - With no grant, rf_w_en <= 0 and addr/data hold their last values.
- Latency: transfer at edge E0 -> rf_w_en high during the cycle after E1 -> register file updated at E2. Minimum 2 edges from transfer to architectural update.
- Same-address writes: age order guarantees the later-accepted value is written last. On a same-edge tie with the same address, the rr winner is written first.
- stall_count: increments on each posedge where a full slot is not granted. Saturates at 16'hFFFF and does not wrap.

Optional Feature:
REGWR_FWD_EN
- Defined: adds inputs rd_addr_s1 and rd_addr_s2 (ADDR_W each) and outputs fwd_s1_hit, fwd_s2_hit (1 bit each) and fwd_s1_data, fwd_s2_data (DATA_W each).
  - fwd_sX_hit = rf_w_en && rf_w_addr == rd_addr_sX && rf_w_addr != 0.
  - fwd_sX_data = rf_w_data.
  - All four outputs are combinational and let the read stage bypass the write landing at the next edge.
- Undefined: these ports and their logic do not exist.

Test Plan:
- Reset, then req0 {addr 3, data 32'hA5A5_0001} for 1 cycle -> rf_w_en=1 exactly one cycle later, rf_w_addr=3, rf_w_data=32'hA5A5_0001, grant_id=0, stall_count=0.
- req0 {5, 32'h11} and req1 {6, 32'h22} on the same edge after reset -> req0 written first, then req1 next cycle (rr=0); stall_count=1; a repeat tie grants req1 first.
- req1 {7, 32'h77} one cycle before req0 {7, 32'h88} -> writes to r7 in order 32'h77 then 32'h88; r7 final value 32'h88.
- req0 {0, 32'hDEAD} with ZERO_REG_PROTECT=1 -> req0_ready=1, rf_w_en stays 0, busy stays 0.
- Hold req0_valid and req1_valid high for 20 cycles with distinct addresses -> rf_w_en high every cycle after fill, grants alternate, and neither ready is low for more than 1 consecutive cycle.
- Assert reset while both slots are full and rf_w_en=1 -> rf_w_en=0 before the next edge, busy=0, stall_count=0, and no write after release until a new transfer.
